// File: rtl/vga_pattern_sequencer.sv
// Frame-aligned selector sharing the VGA RGB output among 2**IDX_W pattern sources; 1-cycle pixel latency, no backpressure.
// Optional black frames between sources; define VGA_SEQ_AUTO_EN to auto-advance every AUTO_FRAMES frames.
module vga_pattern_sequencer #(
  parameter int IDX_W        = 2,
  parameter int BLANK_FRAMES = 1
`ifdef VGA_SEQ_AUTO_EN
  , parameter int AUTO_FRAMES = 120
`endif
) (
  input  logic                       iVGA_CLK,
  input  logic                       iRST_N,
  input  logic                       iFrame_Start,
  input  logic                       iNext,
  input  logic                       iHold,
  input  logic [10*(2**IDX_W)-1:0]   iRed_Bus,
  input  logic [10*(2**IDX_W)-1:0]   iGreen_Bus,
  input  logic [10*(2**IDX_W)-1:0]   iBlue_Bus,
  output logic [9:0]                 oRed,
  output logic [9:0]                 oGreen,
  output logic [9:0]                 oBlue,
  output logic [IDX_W-1:0]           oPat_Idx,
  output logic                       oSwitch
);

  localparam int BW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

  typedef enum logic {SHOW, BLANK} state_t;

  typedef struct packed {
    logic [9:0] red;
    logic [9:0] green;
    logic [9:0] blue;
  } rgb_t;

  state_t          state, stateNext;
  logic [BW-1:0]   blankCnt, blankCntNext;
  logic [IDX_W-1:0] idxNext;
  logic            switchNext;
  logic            reqPend, reqPendNext;
  logic            nextQ, nextEdge;
  logic            served, advance, autoReq;
  rgb_t            pixSel;

  assign nextEdge = iNext & ~nextQ;

  always_comb begin
    stateNext    = state;
    blankCntNext = blankCnt;
    idxNext      = oPat_Idx;
    switchNext   = 1'b0;
    served       = 1'b0;
    advance      = 1'b0;
    case (state)
      SHOW: begin
        if (iFrame_Start && reqPend && !iHold) begin
          served = 1'b1;
          if (BLANK_FRAMES == 0) begin
            advance = 1'b1;
          end else begin
            stateNext    = BLANK;
            blankCntNext = '0;
          end
        end
      end
      BLANK: begin
        // hold is deliberately ignored here: a started blank sequence always completes
        if (iFrame_Start) begin
          if (blankCnt == BLANK_LAST) begin
            advance   = 1'b1;
            stateNext = SHOW;
          end else begin
            blankCntNext = blankCnt + 1'b1;
          end
        end
      end
      default: stateNext = SHOW;
    endcase
    if (advance) begin
      idxNext    = oPat_Idx + 1'b1;
      switchNext = 1'b1;
    end
    // a request arriving on the serving boundary survives the clear
    reqPendNext = (reqPend & ~served) | nextEdge | autoReq;
  end

  always_comb begin
    pixSel = '0;
    if (state != BLANK) begin
      pixSel.red   = iRed_Bus[oPat_Idx*10 +: 10];
      pixSel.green = iGreen_Bus[oPat_Idx*10 +: 10];
      pixSel.blue  = iBlue_Bus[oPat_Idx*10 +: 10];
    end
  end

`ifdef VGA_SEQ_AUTO_EN
  localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'((AUTO_FRAMES > 0) ? AUTO_FRAMES - 1 : 0);

  logic [AW-1:0] frameCnt;

  assign autoReq = (state == SHOW) && iFrame_Start && !iHold && (frameCnt == AUTO_LAST);

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_N || iHold || advance || autoReq) begin
      frameCnt <= '0;
    end else if ((state == SHOW) && iFrame_Start) begin
      frameCnt <= frameCnt + 1'b1;
    end
  end
`else
  assign autoReq = 1'b0;
`endif

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_N) begin
      state    <= SHOW;
      blankCnt <= '0;
      reqPend  <= 1'b0;
      nextQ    <= 1'b0;
      oPat_Idx <= '0;
      oSwitch  <= 1'b0;
      oRed     <= '0;
      oGreen   <= '0;
      oBlue    <= '0;
    end else begin
      state    <= stateNext;
      blankCnt <= blankCntNext;
      reqPend  <= reqPendNext;
      nextQ    <= iNext;
      oPat_Idx <= idxNext;
      oSwitch  <= switchNext;
      oRed     <= pixSel.red;
      oGreen   <= pixSel.green;
      oBlue    <= pixSel.blue;
    end
  end

endmodule
